multicycle_adder: RTL
=====================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and carry-in are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port sub, input, 1 bit, present only with MULTICYCLE_ADDER_SUB_EN: 1 selects subtract.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-015 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; an accept occurs on an edge with in_valid && in_ready, capturing a, b, cin (and sub) and moving to RUN.
REQ-018 SHALL ignore input changes after accept; in_valid outside IDLE has no effect.
REQ-019 SHALL, in RUN, add one CHUNK slice per cycle, LSB slice first, propagating carry between slices, with the initial carry equal to the captured cin.
REQ-020 SHALL, on the edge completing slice NCHUNK-1, enter DONE with out_valid = 1; out_valid therefore rises exactly NCHUNK cycles after the accept edge.
REQ-021 SHALL compute sum = (a + b + cin) mod 2^WIDTH and cout = bit WIDTH of that sum; cout SHALL never be forced to a constant.
REQ-022 SHALL set ovf = 1 when a and b have equal MSBs and sum's MSB differs (operand b taken after inversion in subtract mode).
REQ-023 SHALL hold sum, cout, ovf and out_valid stable in DONE while out_ready = 0.
REQ-024 SHALL, on an edge in DONE with out_ready = 1, clear out_valid and return to IDLE, making in_ready = 1 the following cycle; no accept occurs on that edge.
REQ-025 SHALL retain sum, cout and ovf at their last values after the output handshake, until the next result.
REQ-026 SHALL support NCHUNK = 1 (single-cycle RUN) without special-case failure.

Reset
REQ-027 SHALL, on rst = 1 at an edge, enter IDLE with out_valid = 0, sum = 0, cout = 0, ovf = 0, busy = 0 and in_ready = 1 on the next cycle.
REQ-028 SHALL, on rst during RUN or DONE, abort the operation with no result presented; rst SHALL take priority over every handshake.

Configuration
REQ-029 SHALL, with MULTICYCLE_ADDER_SUB_EN defined, provide the sub port; sub = 1 computes a + ~b + 1 (a - b), cin is ignored, and cout = 1 means no borrow.
REQ-030 SHALL, without MULTICYCLE_ADDER_SUB_EN, omit the sub port and perform addition only.

Verification
REQ-031 SHALL cover the following directed scenario, with WIDTH = 16, CHUNK = 4: a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, cout = 1, ovf = 0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: a = 0x0001, b = 0x0001, cin = 1 -> sum = 0x0003, cout = 0; then a = 0x000F, b = 0x0001, cin = 0 -> sum = 0x0010, so the carry crosses the chunk boundary.
REQ-033 SHALL cover: a = 0x7FFF, b = 0x0001, cin = 0 -> sum = 0x8000, cout = 0, ovf = 1.
REQ-034 SHALL cover back-pressure: out_ready held at 0 for 5 cycles in DONE, with in_valid = 1 and new operands applied -> outputs stable, in_ready = 0, new operands ignored; after release, in_ready = 1 one cycle later.
REQ-035 SHALL cover reset mid-operation: rst asserted 2 cycles after accept -> out_valid never rises, busy = 0 and in_ready = 1 on the cycle after reset, sum = 0.
REQ-036 SHALL cover, with MULTICYCLE_ADDER_SUB_EN defined: sub = 1, a = 0x0005, b = 0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0.

Source files
------------

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: adds one CHUNK-bit slice per cycle, LSB slice first.
// Define MULTICYCLE_ADDER_SUB_EN to add the sub port (a - b via a + ~b + 1).
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a producer holds its data while valid && !ready.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
    logic             carry_q;
    logic [CW-1:0]    idx_q;
    logic [CHUNK:0]   slice_full;
    logic             last_slice;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last_slice = (idx_q == CW'(NCHUNK - 1));

    // One slice of the ripple: the carry out of this slice feeds the next cycle.
    always_comb begin
        slice_full = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                   + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(carry_q);
        acc_d = acc_q;
        acc_d[idx_q*CHUNK +: CHUNK] = slice_full[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_full[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    // Published results only change here, so they survive the output handshake.
                    if (last_slice) begin
                        sum_q  <= acc_d;
                        cout_q <= slice_full[CHUNK];
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
